// File: rtl/square_sequential_if.sv
// Start/done handshake bundle for the sequential squarer: operand in, saturated result out.
interface square_sequential_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] sq;
    logic             done;
    logic             busy;
    logic             ovf;

    modport master (output start, a, input sq, done, busy, ovf);
    modport slave  (input start, a, output sq, done, busy, ovf);
endinterface

// File: rtl/square_sequential.sv
// Multi-cycle shift-add squarer: sq = sat((a*a) >> OUT_SHIFT), one multiplier bit per cycle.
// Build option: SQUARE_SEQUENTIAL_ROUND_EN selects round-half-up instead of truncation.
module square_sequential #(
    parameter int WIDTH     = 32,
    parameter int OUT_SHIFT = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    square_sequential_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_END     = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_p;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sq;
    logic             r_ovf;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_p_next;
    logic [PW:0]      w_p_ext;
    logic [PW:0]      w_r;
    logic             w_last;
    logic             w_sat;

    // Add into the high half, then shift the whole product right by one.
    assign w_addend = r_b[0] ? r_m : '0;
    assign w_sum    = {1'b0, r_p[PW-1:WIDTH]} + {1'b0, w_addend};
    assign w_p_next = PW'({w_sum, r_p[WIDTH-1:0]} >> 1);
    assign w_last   = (r_count == CW'(WIDTH - 1));

`ifdef SQUARE_SEQUENTIAL_ROUND_EN
    // Extra top bit lets a rounding carry out of the full product reach the saturation test.
    assign w_p_ext = {1'b0, w_p_next} + ((PW + 1)'(1) << (OUT_SHIFT - 1));
`else
    assign w_p_ext = {1'b0, w_p_next};
`endif

    assign w_r   = w_p_ext >> OUT_SHIFT;
    assign w_sat = |w_r[PW:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last)    w_state_next = S_END;
            S_END:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_count <= '0;
            r_sq    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.a;
                        r_b     <= bus.a;
                        r_p     <= '0;
                        r_count <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_p     <= w_p_next;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_sq  <= w_sat ? '1 : w_r[WIDTH-1:0];
                        r_ovf <= w_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sq   = r_sq;
    assign bus.ovf  = r_ovf;
    assign bus.done = (r_state == S_END);
    assign bus.busy = (r_state == S_COMPUTE) || (r_state == S_END);
endmodule

// File: tb/tb_square_sequential.sv
// Directed-vector bench for square_sequential: latency, arithmetic, saturation, busy/reset handling.
module tb_square_sequential;
    localparam int WIDTH = 32;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    logic [WIDTH-1:0] last_sq;
    logic             last_ovf;

    square_sequential_if #(.WIDTH(WIDTH)) bus ();

    square_sequential #(.WIDTH(WIDTH), .OUT_SHIFT(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.sq, bus.done, bus.busy, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: sq=%h done=%b busy=%b ovf=%b, want all 0",
                     bus.sq, bus.done, bus.busy, bus.ovf);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.sq, bus.done, bus.busy, bus.ovf} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: sq=%h done=%b busy=%b ovf=%b, want all 0",
                         i, bus.sq, bus.done, bus.busy, bus.ovf);
            end
        end
        last_sq  = '0;
        last_ovf = 1'b0;
    endtask

    // One operation: k counts edges after the accepting edge; done must appear after edge WIDTH,
    // i.e. in the 33rd cycle counting the start-edge cycle as the first.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] exp_sq,
                          input logic exp_ovf, input string nm);
        int k;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) break;
            if (k == 5) begin
                n_checks++;
                if (bus.busy !== 1'b1 || bus.sq !== last_sq || bus.ovf !== last_ovf) begin
                    n_fail++;
                    $display("FAIL %s_compute_hold: busy=%b sq=%h ovf=%b, want busy=1 sq=%h ovf=%b",
                             nm, bus.busy, bus.sq, bus.ovf, last_sq, last_ovf);
                end
            end
        end
        n_checks++;
        if (k != WIDTH) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d edges, want %0d", nm, k, WIDTH);
        end
        n_checks++;
        if (bus.sq !== exp_sq || bus.ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s_result: sq=%h ovf=%b, want sq=%h ovf=%b",
                     nm, bus.sq, bus.ovf, exp_sq, exp_ovf);
        end
        last_sq  = exp_sq;
        last_ovf = exp_ovf;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b busy=%b after pulse, want 0/0",
                     nm, bus.done, bus.busy);
        end
    endtask

    task automatic test_vectors();
        run_op(32'h0000_3000, 32'h0000_0009, 1'b0, "three");
        run_op(32'h0001_0000, 32'h0000_0100, 1'b0, "sixteen");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
        run_op(32'h0FFF_FFFF, 32'hFFFF_FFE0, 1'b0, "max_fit");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "saturate");
        run_op(32'h0000_2000, 32'h0000_0004, 1'b0, "two");
`ifdef SQUARE_SEQUENTIAL_ROUND_EN
        run_op(32'h0000_0B51, 32'h0000_0001, 1'b0, "round_half");
`else
        run_op(32'h0000_0B51, 32'h0000_0000, 1'b0, "round_half");
`endif
    endtask

    task automatic test_start_ignored();
        int dones;
        logic [WIDTH-1:0] sq_at_done;
        dones      = 0;
        sq_at_done = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0000_3000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                bus.start = 1'b1;
                bus.a     = 32'h0000_5000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                sq_at_done = bus.sq;
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL busy_start_count: %0d done pulses, want 1", dones);
        end
        n_checks++;
        if (sq_at_done !== 32'h0000_0009) begin
            n_fail++;
            $display("FAIL busy_start_result: sq=%h, want 00000009", sq_at_done);
        end
        last_sq  = 32'h0000_0009;
        last_ovf = 1'b0;
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0000_5000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.sq, bus.done, bus.busy, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL abort_async: sq=%h done=%b busy=%b ovf=%b, want all 0",
                     bus.sq, bus.done, bus.busy, bus.ovf);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy || bus.sq !== '0 || bus.ovf) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with activity after reset, want 0", dones);
        end
        last_sq  = '0;
        last_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e1, e2, k;
        logic [WIDTH-1:0] sq1, sq2;
        e1 = -1; e2 = -1; k = 0;
        sq1 = '0; sq2 = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0000_3000;
        @(posedge clk);
        #1;
        bus.a = 32'h0000_2000;
        while (k < 100 && e2 < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) begin
                if (e1 < 0) begin
                    e1  = k;
                    sq1 = bus.sq;
                end else begin
                    e2  = k;
                    sq2 = bus.sq;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (e1 != WIDTH || sq1 !== 32'h0000_0009) begin
            n_fail++;
            $display("FAIL b2b_first: done at %0d sq=%h, want %0d sq=00000009", e1, sq1, WIDTH);
        end
        n_checks++;
        if (e2 - e1 != WIDTH + 2 || sq2 !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL b2b_second: gap=%0d sq=%h, want gap=%0d sq=00000004",
                     e2 - e1, sq2, WIDTH + 2);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_sq  = '0;
        last_ovf = 1'b0;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
